// File: rtl/offchip_sram_pkg.sv
// Shared types and default widths for the off-chip SRAM arbiter.
package offchip_sram_pkg;

  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DATA_W = 16;

  typedef logic [3:0] sram_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_arb_state_t;

  typedef struct packed {
    logic                   write;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/offchip_sram_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the side not granted last.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // One-hot grant selection
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/offchip_sram_arbiter.sv
// Shares the single off-chip SRAM port between two requesters: grant, fixed-width
// strobe window, read-data capture, one-cycle done pulse.
module offchip_sram_arbiter
  import offchip_sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk2,
  input  logic              NReset,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic [ADDR_W-1:0] OFAdd,
  output logic              OFRead,
  output logic              OFWrite,
  output logic [DATA_W-1:0] OFDataout,
  input  logic [DATA_W-1:0] OFDatain
);

  localparam sram_cnt_t CNT_INIT = sram_cnt_t'(ACCESS_CYCLES - 1);

  sram_arb_state_t   state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_id_q, gnt_id_d;
  sram_cnt_t         count_q, count_d;
  logic [ADDR_W-1:0] of_add_q, of_add_d;
  logic [DATA_W-1:0] of_dout_q, of_dout_d;
  logic              of_rd_q, of_rd_d;
  logic              of_wr_q, of_wr_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        gnt_s;
  sram_req_t         sel_s;

  rr_arbiter2 u_rr (
    .req_i        ({r1_req, r0_req}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt_s)
  );

  // Request fields of whichever side the arbiter picks this cycle
  always_comb begin
    if (gnt_s[1]) begin
      sel_s.write = r1_write;
      sel_s.addr  = SRAM_ADDR_W'(r1_addr);
      sel_s.wdata = SRAM_DATA_W'(r1_wdata);
    end else begin
      sel_s.write = r0_write;
      sel_s.addr  = SRAM_ADDR_W'(r0_addr);
      sel_s.wdata = SRAM_DATA_W'(r0_wdata);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    count_d      = count_q;
    of_add_d     = of_add_q;
    of_dout_d    = of_dout_q;
    of_rd_d      = of_rd_q;
    of_wr_d      = of_wr_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          state_d      = ACCESS;
          gnt_id_d     = gnt_s[1];
          last_grant_d = gnt_s[1];
          count_d      = CNT_INIT;
          of_add_d     = ADDR_W'(sel_s.addr);
          of_dout_d    = DATA_W'(sel_s.wdata);
          of_rd_d      = ~sel_s.write;
          of_wr_d      = sel_s.write;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (count_q == 4'd0) begin
          state_d = DONE;
          of_rd_d = 1'b0;
          of_wr_d = 1'b0;
          done0_d = ~gnt_id_q;
          done1_d = gnt_id_q;
          // Address is still driven on this edge, so OFDatain belongs to this access
          if (of_rd_q && gnt_id_q) begin
            rdata1_d = OFDatain;
          end else if (of_rd_q) begin
            rdata0_d = OFDatain;
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        of_add_d  = '0;
        of_dout_d = '0;
      end
      default: begin
        state_d   = IDLE;
        of_add_d  = '0;
        of_dout_d = '0;
        of_rd_d   = 1'b0;
        of_wr_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      count_q      <= 4'd0;
      of_add_q     <= '0;
      of_dout_q    <= '0;
      of_rd_q      <= 1'b0;
      of_wr_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      count_q      <= count_d;
      of_add_q     <= of_add_d;
      of_dout_q    <= of_dout_d;
      of_rd_q      <= of_rd_d;
      of_wr_q      <= of_wr_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign OFAdd     = of_add_q;
  assign OFDataout = of_dout_q;
  assign OFRead    = of_rd_q;
  assign OFWrite   = of_wr_q;
  assign r0_done   = done0_q;
  assign r1_done   = done1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_offchip_sram_arbiter.sv
// Bench for offchip_sram_arbiter: vector table, corner-case sequences and a
// randomized run against a transaction-level model. Instances use ACCESS_CYCLES 2, 1, 15.
module tb_offchip_sram_arbiter;

  localparam int AW = 17;
  localparam int DW = 16;
  localparam int NDUT = 3;
  localparam int AC_MAIN = 2;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic          req0_s [NDUT];
  logic          r1_req, w0, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] add_s [NDUT];
  logic [DW-1:0] dout_s [NDUT];
  logic [DW-1:0] din_s [NDUT];
  logic [DW-1:0] rdata0_s [NDUT];
  logic [DW-1:0] rdata1_s [NDUT];
  logic          rd_s [NDUT];
  logic          wr_s [NDUT];
  logic          done0_s [NDUT];
  logic          done1_s [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM contents seen by the arbiter
  function automatic logic [DW-1:0] sram_data(input logic [AW-1:0] a);
    if (a == 17'h00010) return 16'hBEEF;
    return a[15:0] ^ 16'h5A3C ^ {15'h0000, a[16]};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int AC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    assign din_s[g] = sram_data(add_s[g]);
    offchip_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) u_dut (
      .clk2(clk), .NReset(nreset),
      .r0_req(req0_s[g]), .r0_write(w0), .r0_addr(a0), .r0_wdata(d0),
      .r0_rdata(rdata0_s[g]), .r0_done(done0_s[g]),
      .r1_req((g == 0) ? r1_req : 1'b0), .r1_write(w1), .r1_addr(a1), .r1_wdata(d1),
      .r1_rdata(rdata1_s[g]), .r1_done(done1_s[g]),
      .OFAdd(add_s[g]), .OFRead(rd_s[g]), .OFWrite(wr_s[g]),
      .OFDataout(dout_s[g]), .OFDatain(din_s[g])
    );
  end

  typedef struct {
    logic q0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic q1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic exp_id; logic [DW-1:0] exp_rd0, exp_rd1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    for (int g = 0; g < NDUT; g++) req0_s[g] = 1'b0;
    r1_req = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = 17'h0; a1 = 17'h0; d0 = 16'h0; d1 = 16'h0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  // One transaction on the main instance; returns after the cycle following done
  task automatic run_vec(input vec_t v, input int idx);
    int strobes, lat;
    logic bad_add, bad_kind, bad_dout, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ew = v.exp_id ? v.w1 : v.w0;
    ea = v.exp_id ? v.a1 : v.a0;
    ed = v.exp_id ? v.d1 : v.d0;
    req0_s[0] = v.q0; w0 = v.w0; a0 = v.a0; d0 = v.d0;
    r1_req = v.q1; w1 = v.w1; a1 = v.a1; d1 = v.d1;
    strobes = 0; lat = 0; bad_add = 1'b0; bad_kind = 1'b0; bad_dout = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rd_s[0] || wr_s[0]) begin
        strobes++;
        if (add_s[0] !== ea) bad_add = 1'b1;
        if (dout_s[0] !== ed) bad_dout = 1'b1;
        if (rd_s[0] !== ~ew || wr_s[0] !== ew) bad_kind = 1'b1;
      end
      if (done0_s[0] || done1_s[0]) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("v%0d_done", idx), {done1_s[0], done0_s[0]}, v.exp_id ? 2'b10 : 2'b01);
    chk($sformatf("v%0d_latency", idx), lat, AC_MAIN + 1);
    chk($sformatf("v%0d_strobe_width", idx), strobes, AC_MAIN);
    chk($sformatf("v%0d_addr_bad", idx), bad_add, 1'b0);
    chk($sformatf("v%0d_dout_bad", idx), bad_dout, 1'b0);
    chk($sformatf("v%0d_strobe_kind_bad", idx), bad_kind, 1'b0);
    chk($sformatf("v%0d_rdata0", idx), rdata0_s[0], v.exp_rd0);
    chk($sformatf("v%0d_rdata1", idx), rdata1_s[0], v.exp_rd1);
    req0_s[0] = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_cleared", idx), {done1_s[0], done0_s[0]}, 2'b00);
    chk($sformatf("v%0d_idle_addr", idx), add_s[0], 17'h0);
    chk($sformatf("v%0d_idle_strobe", idx), {rd_s[0], wr_s[0]}, 2'b00);
  endtask

  // Strobe width and done latency of an aux instance with a different ACCESS_CYCLES
  task automatic measure(input int g, input int ac);
    int s, lat;
    s = 0; lat = 0;
    w0 = 1'b0; a0 = 17'h00777; req0_s[g] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rd_s[g]) s++;
      if (done0_s[g]) begin
        lat = n;
        break;
      end
    end
    req0_s[g] = 1'b0;
    chk($sformatf("ac%0d_strobe_width", ac), s, ac);
    chk($sformatf("ac%0d_latency", ac), lat, ac + 1);
    chk($sformatf("ac%0d_rdata", ac), rdata0_s[g], sram_data(17'h00777));
    @(negedge clk);
  endtask

  initial begin
    int ndone, nstr;
    logic [1:0] got;
    int e, m_free, m_gnt;
    logic m_last, m_id, m_w, strobe, in_win, dn;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic [DW-1:0] exp_rd [2];

    vecs[0] = '{1'b1, 1'b0, 17'h00010, 16'h0000, 1'b0, 1'b0, 17'h00000, 16'h0000,
                1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 17'h00000, 16'h0000, 1'b1, 1'b1, 17'h1FFFF, 16'h1234,
                1'b1, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 17'h00555, 16'hAAAA, 1'b1, 1'b0, 17'h00ABC, 16'h0000,
                1'b0, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 17'h00020, 16'h0000, 1'b1, 1'b0, 17'h00ABC, 16'h0000,
                1'b1, 16'hBEEF, 16'h5080};
    vecs[4] = '{1'b0, 1'b0, 17'h00000, 16'h0000, 1'b1, 1'b0, 17'h00010, 16'h5555,
                1'b1, 16'hBEEF, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 17'h1FFFF, 16'h0000, 1'b1, 1'b1, 17'h00300, 16'h7777,
                1'b0, 16'hA5C2, 16'hBEEF};

    nreset = 1'b0;
    do_reset();
    nreset = 1'b0;
    #1;
    chk("reset_addr", add_s[0], 17'h0);
    chk("reset_dout", dout_s[0], 16'h0);
    chk("reset_strobes", {rd_s[0], wr_s[0]}, 2'b00);
    chk("reset_done", {done1_s[0], done0_s[0]}, 2'b00);
    chk("reset_rdata0", rdata0_s[0], 16'h0);
    chk("reset_rdata1", rdata1_s[0], 16'h0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Both held continuously from reset: strict alternation starting with r0
    do_reset();
    req0_s[0] = 1'b1; w0 = 1'b0; a0 = 17'h00100;
    r1_req = 1'b1; w1 = 1'b0; a1 = 17'h00200;
    for (int t = 0; t < 6; t++) begin
      got = 2'b00;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (done0_s[0] || done1_s[0]) begin
          got = {done1_s[0], done0_s[0]};
          break;
        end
      end
      chk($sformatf("fair_%0d", t), got, (t % 2 == 0) ? 2'b01 : 2'b10);
    end
    req0_s[0] = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("fair_idle", {rd_s[0], wr_s[0]}, 2'b00);

    // Request dropped during ACCESS still completes, and only once
    req0_s[0] = 1'b1; w0 = 1'b1; a0 = 17'h00400; d0 = 16'hC0DE;
    @(negedge clk);
    chk("drop_strobe", wr_s[0], 1'b1);
    req0_s[0] = 1'b0;
    ndone = 0; nstr = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done0_s[0]) ndone++;
      if (rd_s[0] || wr_s[0]) nstr++;
    end
    chk("drop_done_count", ndone, 1);
    chk("drop_strobe_cycles", nstr, AC_MAIN);

    // Reset during the second ACCESS cycle
    req0_s[0] = 1'b1; w0 = 1'b0; a0 = 17'h00010;
    repeat (2) @(negedge clk);
    chk("rst_pre_strobe", rd_s[0], 1'b1);
    #1 nreset = 1'b0;
    #1;
    chk("rst_strobes_drop", {rd_s[0], wr_s[0]}, 2'b00);
    chk("rst_addr_clear", add_s[0], 17'h0);
    req0_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    ndone = 0; nstr = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done0_s[0] || done1_s[0]) ndone++;
      if (rd_s[0] || wr_s[0]) nstr++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_no_strobe", nstr, 0);
    chk("rst_rdata0", rdata0_s[0], 16'h0);
    vecs[0] = '{1'b0, 1'b0, 17'h00000, 16'h0000, 1'b1, 1'b0, 17'h00010, 16'h0000,
                1'b1, 16'h0000, 16'hBEEF};
    run_vec(vecs[0], 10);

    measure(1, 1);
    measure(2, 15);

    // Randomized traffic against a transaction-level model of the main instance
    do_reset();
    e = 0; m_free = 0; m_gnt = -100; m_last = 1'b1; m_id = 1'b0; m_w = 1'b0;
    m_a = 17'h0; m_d = 16'h0; exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    for (int c = 0; c < 1500; c++) begin
      if (req0_s[0] && done0_s[0]) req0_s[0] = 1'b0;
      else if (!req0_s[0] && $urandom_range(0, 2) == 0) begin
        req0_s[0] = 1'b1; w0 = 1'($urandom_range(0, 1));
        a0 = AW'($urandom()); d0 = DW'($urandom());
      end
      if (r1_req && done1_s[0]) r1_req = 1'b0;
      else if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_req = 1'b1; w1 = 1'($urandom_range(0, 1));
        a1 = AW'($urandom()); d1 = DW'($urandom());
      end
      e++;
      if (e >= m_free && (req0_s[0] || r1_req)) begin
        m_id = (req0_s[0] && r1_req) ? ~m_last : r1_req;
        m_w = m_id ? w1 : w0;
        m_a = m_id ? a1 : a0;
        m_d = m_id ? d1 : d0;
        m_gnt = e; m_free = e + AC_MAIN + 2; m_last = m_id;
      end
      strobe = (e >= m_gnt) && (e <= m_gnt + AC_MAIN - 1);
      in_win = (e >= m_gnt) && (e <= m_gnt + AC_MAIN);
      dn = (e == m_gnt + AC_MAIN);
      if (dn && !m_w) exp_rd[m_id] = sram_data(m_a);
      @(negedge clk);
      chk("rnd_read", rd_s[0], strobe && !m_w);
      chk("rnd_write", wr_s[0], strobe && m_w);
      chk("rnd_addr", add_s[0], in_win ? m_a : 17'h0);
      chk("rnd_dout", dout_s[0], in_win ? m_d : 16'h0);
      chk("rnd_done0", done0_s[0], dn && !m_id);
      chk("rnd_done1", done1_s[0], dn && m_id);
      chk("rnd_rdata0", rdata0_s[0], exp_rd[0]);
      chk("rnd_rdata1", rdata1_s[0], exp_rd[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/offchip_sram_arbiter.md
Name: offchip_sram_arbiter

Overview:
- Sequences and shares the single off-chip SRAM port between two on-chip requesters (r0, r1).
- Each requester uses a level req / single-cycle done handshake.
- The arbiter grants round-robin and latches the request.
- It drives the SRAM address, data and strobe lines for a fixed access window, captures read data, then returns to idle.
- Sits between the processing core/DMA engines and the SRAM wrapper; it is the only driver of the OFAdd/OFRead/OFWrite/OFDataout lines.

Parameters:
- ADDR_W, 17, SRAM word address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, cycles the read/write strobe is held per access; legal range 1..15.

Ports:
- clk2  in  1  system clock, rising edge.
- NReset  in  1  asynchronous active-low reset.
- r0_req  in  1  requester 0 access request (level).
- r0_write  in  1  requester 0: 1 = write, 0 = read; sampled at grant.
- r0_addr  in  ADDR_W  requester 0 address; sampled at grant.
- r0_wdata  in  DATA_W  requester 0 write data; sampled at grant.
- r0_rdata  out  DATA_W  requester 0 read data; valid from the done cycle onward.
- r0_done  out  1  one-cycle completion pulse to requester 0.
- r1_req, r1_write, r1_addr, r1_wdata, r1_rdata, r1_done: same as r0, for requester 1.
- OFAdd  out  ADDR_W  SRAM address.
- OFRead  out  1  SRAM read strobe.
- OFWrite  out  1  SRAM write strobe.
- OFDataout  out  DATA_W  SRAM write data.
- OFDatain  in  DATA_W  SRAM read data.

Behaviour:
- Reset (async, NReset=0):
  - state=IDLE, last_grant=1 (so r0 wins the first tie).
  - Count=0; OFAdd, OFDataout, OFRead, OFWrite = 0.
  - r0/r1_done=0, r0/r1_rdata=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On grant (edge k): latch addr/wdata/write/grant id into the OF* registers, update last_grant, count=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS, cycles k+1..k+ACCESS_CYCLES:
  - OFRead=~write or OFWrite=write, held constant; OFAdd and OFDataout stable.
  - count decrements each cycle. At count==0 the next edge goes to DONE; for reads, OFDatain is captured into the granted requester's rdata register on that edge.
- DONE, cycle k+ACCESS_CYCLES+1:
  - Strobes=0; granted done=1 for exactly one cycle; the other done stays 0.
  - req inputs are ignored in this state. Next state is IDLE.
- Requester contract: drop req in the cycle done is seen. A req still high in the following IDLE cycle is a new transaction, subject to round-robin.
- Latency: req sampled at edge k → done high during cycle k+ACCESS_CYCLES+1. Minimum issue spacing is ACCESS_CYCLES+2 cycles.
- OFRead and OFWrite are never high simultaneously; both are 0 outside ACCESS.
- OFAdd and OFDataout return to 0 on entering IDLE.
- req deasserted during ACCESS: the access still completes and done still pulses.
- rdata retains its last value until the next read completion for that requester; writes do not modify rdata.
- Reset mid-ACCESS: strobes drop immediately (async), no done is issued, and the latched transaction is discarded.
- Fairness: with both reqs held continuously, grants strictly alternate r0, r1, r0, ...

Decomposition:
- Package offchip_sram_pkg holds:
  - ADDR_W/DATA_W default constants.
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} sram_arb_state_t.
  - typedef struct {write, addr, wdata} sram_req_t.
- One sub-module, rr_arbiter2: combinational 2-way round-robin grant from req[1:0] and last_grant, with a one-hot grant output. The FSM and datapath stay in offchip_sram_arbiter.

Test Plan (ACCESS_CYCLES=2 unless stated):
- r0 read of 0x00010, SRAM model returns 0xBEEF:
  - OFRead=1 with OFAdd=0x00010 for exactly 2 cycles.
  - r0_done pulses 3 cycles after req is sampled; r0_rdata=0xBEEF.
  - r1_done stays 0.
- r1 write of 0x1234 to 0x1FFFF (max address):
  - OFWrite=1, OFDataout=0x1234, OFAdd=0x1FFFF for 2 cycles; OFRead stays 0.
  - r1_done pulses once; r1_rdata unchanged.
- r0 and r1 both request from reset:
  - r0 is served first, then r1 (each with done), then IDLE.
  - Holding both reqs for 6 transactions gives grant order r0,r1,r0,r1,r0,r1.
- r0 drops req one cycle into ACCESS: the access completes, r0_done pulses, no second transaction starts.
- NReset asserted in the second ACCESS cycle:
  - OFRead/OFWrite go to 0 immediately; no done.
  - After release, a new r1 read completes normally.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=15: strobe width is 1 and 15 cycles respectively; done latency is 2 and 16 cycles after the grant edge.
